reg_file_mp: RTL and testbench

- Parametrised multi-port integer register file for the RISC-V datapath. Generalises the single-write, dual-read 64x32 file.
- Provides NRD combinational read ports and NWR write ports with fixed write priority.
- x0 is hardwired to zero. Optional write-to-read bypass.
- An integrated busy scoreboard lets the pipeline detect read-after-write hazards on registers with in-flight writebacks.

---
 rtl/reg_file_pkg.sv | 25 ++
 rtl/reg_file_mp_scoreboard.sv | 44 ++++
 rtl/reg_file_mp.sv | 77 +++++++
 tb/tb_reg_file_mp.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types and the write-port priority resolver for reg_file_mp.
package reg_file_pkg;
    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);
    localparam int MAX_WR    = 16;
    localparam int WIDX_W    = $clog2(MAX_WR);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

    typedef struct packed {
        logic              valid;
        logic [WIDX_W-1:0] idx;
    } win_t;

    // Highest-index set bit of a per-port match vector wins.
    function automatic win_t winner_port(input logic [MAX_WR-1:0] m);
        win_t w;
        w = '{valid: 1'b0, idx: '0};
        for (int p = 0; p < MAX_WR; p++)
            if (m[p]) w = '{valid: 1'b1, idx: WIDX_W'(p)};
        return w;
    endfunction
endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// reg_scoreboard: per-register busy bits with issue/writeback/flush resolution.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NWR   = 2,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              flush,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy,
    output logic [NREGS-1:0]  busy_vec
);
    logic [NREGS-1:0] busy_q, busy_d;

    // Issue beats a same-cycle writeback: the new producer owns the register.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREGS; r++) begin
            for (int p = 0; p < NWR; p++)
                if (wr_en[p] && wr_addr[p*AW +: AW] == AW'(r)) busy_d[r] = 1'b0;
            if (iss_en && iss_addr == AW'(r)) busy_d[r] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (flush) busy_d = '0;
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) busy_q <= '0;
        else busy_q <= busy_d;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        assign rd_busy[i] = busy_q[rd_addr[i*AW +: AW]];
    end

    assign busy_vec = busy_q;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port integer register file, x0 hardwired, optional write bypass,
// with an integrated busy scoreboard for RAW hazard detection.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic [NREGS-1:0]    busy_vec
);
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    win_t            wr_win [NREGS];
    win_t            rd_win [NRD];

    function automatic logic [MAX_WR-1:0] match(input logic [AW-1:0] a,
                                                input logic [NWR-1:0] en,
                                                input logic [NWR*AW-1:0] addr);
        logic [MAX_WR-1:0] m;
        m = '0;
        for (int p = 0; p < NWR; p++) m[p] = en[p] && addr[p*AW +: AW] == a;
        return m;
    endfunction

    for (genvar r = 0; r < NREGS; r++) begin : g_wr
        assign wr_win[r] = winner_port(match(AW'(r), wr_en, wr_addr));
    end

    always_comb begin
        regs_d = regs_q;
        for (int r = 1; r < NREGS; r++)
            if (wr_win[r].valid) regs_d[r] = wr_data[int'(wr_win[r].idx)*XLEN +: XLEN];
        regs_d[0] = '0;
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        else regs_q <= regs_d;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        assign a         = rd_addr[i*AW +: AW];
        assign rd_win[i] = winner_port(match(a, wr_en, wr_addr));
        assign rd_data[i*XLEN +: XLEN] =
            (!reset || a == '0) ? '0 :
            (BYPASS != 0 && rd_win[i].valid) ? wr_data[int'(rd_win[i].idx)*XLEN +: XLEN] :
            regs_q[a];
    end

    reg_scoreboard #(.NREGS(NREGS), .NWR(NWR), .NRD(NRD), .AW(AW)) u_sb (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .iss_en  (iss_en),
        .iss_addr(iss_addr),
        .flush   (flush),
        .rd_addr (rd_addr),
        .rd_busy (rd_busy),
        .busy_vec(busy_vec)
    );
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed checks of reg_file_mp with and without write bypass.
module tb_reg_file_mp;
    import reg_file_pkg::*;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [9:0]   rd_addr = '0;
    logic [1:0]   wr_en = '0;
    logic [9:0]   wr_addr = '0;
    logic [127:0] wr_data = '0;
    logic         iss_en = 1'b0;
    logic [4:0]   iss_addr = '0;
    logic         flush = 1'b0;

    logic [127:0] rd_data_b, rd_data_n;
    logic [1:0]   rd_busy_b, rd_busy_n;
    logic [31:0]  busy_vec_b, busy_vec_n;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    reg_file_mp #(.BYPASS(1)) dut_b (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec_b)
    );

    reg_file_mp #(.BYPASS(0)) dut_n (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec_n)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [1:0] en, input logic [4:0] a0, input xword_t d0,
                      input logic [4:0] a1, input xword_t d1);
        wr_en   = en;
        wr_addr = {a1, a0};
        wr_data = {d1, d0};
    endtask

    task automatic idle();
        wr(2'b00, 5'd0, '0, 5'd0, '0);
        iss_en = 1'b0;
        flush  = 1'b0;
    endtask

    initial begin
        wr(2'b11, 5'd5, 64'hDEAD, 5'd5, 64'hDEAD);
        iss_en   = 1'b1;
        iss_addr = 5'd5;
        rd_addr  = {5'd5, 5'd5};
        tick();
        tick();
        chk("rst_held_rd", rd_data_b[63:0], 64'h0);
        chk("rst_held_busy", 64'(busy_vec_b), 64'h0);
        idle();
        #2 reset = 1'b1;
        tick();
        chk("rst_rd_x5", rd_data_b[63:0], 64'h0);
        chk("rst_busy_vec", 64'(busy_vec_b), 64'h0);

        wr(2'b01, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, '0);
        iss_en   = 1'b1;
        iss_addr = 5'd0;
        rd_addr  = {5'd0, 5'd0};
        #1 chk("x0_bypass", rd_data_b[63:0], 64'h0);
        tick();
        idle();
        #1 chk("x0_read", rd_data_b[63:0], 64'h0);
        chk("x0_busy", 64'(busy_vec_b), 64'h0);

        wr(2'b11, 5'd7, 64'h11, 5'd7, 64'h22);
        rd_addr = {5'd7, 5'd0};
        #1 chk("conf_byp", rd_data_b[127:64], 64'h22);
        chk("conf_nobyp", rd_data_n[127:64], 64'h0);
        tick();
        idle();
        #1 chk("conf_x7_b", rd_data_b[127:64], 64'h22);
        chk("conf_x7_n", rd_data_n[127:64], 64'h22);

        wr(2'b01, 5'd3, 64'h1234, 5'd0, '0);
        tick();
        wr(2'b10, 5'd0, '0, 5'd3, 64'hABCD);
        rd_addr = {5'd0, 5'd3};
        #1 chk("byp_same", rd_data_b[63:0], 64'hABCD);
        chk("nobyp_old", rd_data_n[63:0], 64'h1234);
        tick();
        idle();
        #1 chk("nobyp_next", rd_data_n[63:0], 64'hABCD);

        iss_en   = 1'b1;
        iss_addr = 5'd9;
        rd_addr  = {5'd9, 5'd0};
        #1 chk("sb_iss_same", 64'(rd_busy_b[1]), 64'h0);
        tick();
        idle();
        #1 chk("sb_iss_next", 64'(rd_busy_b[1]), 64'h1);
        chk("sb_vec9", 64'(busy_vec_b), 64'h200);
        wr(2'b01, 5'd9, 64'h99, 5'd0, '0);
        iss_en   = 1'b1;
        iss_addr = 5'd9;
        tick();
        idle();
        #1 chk("sb_iss_wins", 64'(rd_busy_b[1]), 64'h1);
        wr(2'b10, 5'd0, '0, 5'd9, 64'h9A);
        #1 chk("sb_wb_same", 64'(rd_busy_b[1]), 64'h1);
        tick();
        idle();
        #1 chk("sb_wb_clear", 64'(rd_busy_b[1]), 64'h0);
        chk("sb_x9_data", rd_data_b[127:64], 64'h9A);

        iss_en = 1'b1;
        iss_addr = 5'd4;
        tick();
        iss_addr = 5'd9;
        tick();
        iss_addr = 5'd31;
        tick();
        iss_en = 1'b0;
        #1 chk("fl_pre", 64'(busy_vec_b), 64'h8000_0210);
        flush    = 1'b1;
        iss_en   = 1'b1;
        iss_addr = 5'd12;
        tick();
        idle();
        #1 chk("fl_vec", 64'(busy_vec_b), 64'h0);
        rd_addr = {5'd7, 5'd3};
        #1 chk("fl_x3", rd_data_b[63:0], 64'hABCD);
        chk("fl_x7", rd_data_b[127:64], 64'h22);

        iss_en   = 1'b1;
        iss_addr = 5'd7;
        tick();
        idle();
        wr(2'b01, 5'd7, 64'h77, 5'd0, '0);
        #2 reset = 1'b0;
        #1 chk("mid_rst_x7", rd_data_b[127:64], 64'h0);
        chk("mid_rst_busy", 64'(busy_vec_b), 64'h0);
        tick();
        idle();
        #2 reset = 1'b1;
        tick();
        chk("mid_rst_after", rd_data_b[127:64], 64'h0);
        chk("mid_rst_x3", rd_data_n[63:0], 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
